psum_collector: RTL
===================

PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 Parameter BIT_WIDTH, default 8: width of one partial sum.
REQ-002 Parameter NUM_KERNEL, default 4: number of kernel lanes (kn0..kn3).
REQ-003 Parameter FIFO_DEPTH, default 8: entries per lane FIFO, power of two.
REQ-004 Parameter REG_WIDTH, default 32: control and counter width.
REQ-005 Port clk  input  1  the single clock; all logic SHALL be synchronous to clk.
REQ-006 Port rst  input  1  synchronous, active-high reset.
REQ-007 Ports i_psum_kn0..i_psum_kn3  input  BIT_WIDTH each  partial sums from accelerator_core.
REQ-008 Ports i_psum_kn0_val..i_psum_kn3_val  input  1 each  per-lane valid strobes.
REQ-009 Port i_conf_ctrl  input  REG_WIDTH  bit0 = enable, bit1 = clear; other bits ignored.
REQ-010 Port o_data  output  BIT_WIDTH*NUM_KERNEL  packed word {kn3,kn2,kn1,kn0}, with kn0 in bits [7:0].
REQ-011 Port o_data_val  output  1  o_data is valid.
REQ-012 Port i_data_rdy  input  1  the consumer accepts o_data.
REQ-013 Port o_overflow  output  1  sticky flag: a psum was dropped.
REQ-014 Port o_word_cnt  output  REG_WIDTH  count of words handed off.

Function
REQ-015 Each lane SHALL write into its own FIFO when its _val is 1, enable is 1, clear is 0, and the FIFO is not full.
REQ-016 At full, a write SHALL still be accepted if the same lane pops in that same cycle.
REQ-017 A write that cannot be accepted SHALL drop the psum and set o_overflow on the next edge; o_overflow stays set until rst or clear.
REQ-018 Pop condition: all NUM_KERNEL FIFOs are non-empty AND (o_data_val==0 OR i_data_rdy==1).
REQ-019 On pop, all lane FIFOs SHALL pop together, and the output register SHALL load the packed heads with o_data_val=1.
REQ-020 If o_data_val==1, i_data_rdy==1, and no pop occurs, o_data_val SHALL clear on the next edge.
REQ-021 While o_data_val==1 and i_data_rdy==0, o_data SHALL hold stable.
REQ-022 Latency: psum valid in cycle N, with all lanes present and the output free -> o_data_val=1 in cycle N+2.
REQ-023 Throughput: one word per cycle while i_data_rdy=1 and lanes are fed continuously.
REQ-024 o_word_cnt SHALL increment on each cycle with o_data_val && i_data_rdy, wrapping modulo 2^REG_WIDTH.
REQ-025 enable=0 SHALL block only FIFO writes; draining and output handshaking SHALL continue.
REQ-026 clear=1 SHALL, on the next edge, empty all FIFOs and set o_data_val=0, o_overflow=0, o_word_cnt=0; it has priority over any concurrent write, pop or handshake.
REQ-027 Lanes that get ahead SHALL wait; no word SHALL ever be formed from a partial set of lanes.

Reset
REQ-028 On rst=1 at a clk edge: all FIFO pointers and counts 0, o_data=0, o_data_val=0, o_overflow=0, o_word_cnt=0.
REQ-029 rst asserted mid-transfer SHALL discard all buffered and in-flight data, with no partial word afterwards.
REQ-030 rst SHALL take priority over clear and over all datapath activity.

Structure
REQ-031 BIT_WIDTH, NUM_KERNEL, REG_WIDTH defaults and the i_conf_ctrl bit positions (CTRL_EN=0, CTRL_CLR=1) SHALL reside in the shared accelerator package.
REQ-032 Each lane FIFO SHALL be an instance of one sub-module, sync_fifo (parameters: width, depth), with a full/empty/count interface and support for simultaneous push and pop.
REQ-033 psum_collector SHALL contain only the lane FIFO array, the pop/output register logic, the overflow flag and the word counter.

Verification
REQ-034 enable=1, rdy=1; one cycle with kn0..kn3 = 0x01,0x02,0x03,0x04 valid -> two cycles later o_data=0x04030201, o_data_val=1 for one cycle, o_word_cnt=1.
REQ-035 kn0 valid at cycles 0..2 (0x10,0x11,0x12), other lanes valid only at cycle 2 (0x20,0x30,0x40) -> first word 0x40302010; kn0 retains 0x11 and 0x12.
REQ-036 rdy=0; feed 10 full sets (values 0..9 on every lane) -> one word held in the output register plus 8 in the FIFOs, the 10th set dropped, o_overflow=1; then rdy=1 -> 9 words 0x00000000..0x08080808 in order, o_word_cnt=9.
REQ-037 Continuous valid on all lanes with rdy=1 for 20 cycles -> o_data_val high for 20 consecutive cycles, o_word_cnt=20, o_overflow=0.
REQ-038 With 3 words buffered, pulse i_conf_ctrl=0x3 for one cycle -> next cycle o_data_val=0, o_word_cnt=0, o_overflow=0, and no stale words afterwards.
REQ-039 enable=0 with valid strobes -> no words and no overflow; rst mid-stream -> all outputs return to 0 on the next edge.

Source files
------------

// File: rtl/psum_collector_pkg.sv
// Shared accelerator definitions: default datapath widths and i_conf_ctrl bit positions.
package psum_collector_pkg;
  localparam int BIT_WIDTH_DEF  = 8;
  localparam int NUM_KERNEL_DEF = 4;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int REG_WIDTH_DEF  = 32;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;
endpackage

// File: rtl/psum_collector_sync_fifo.sv
// Single-clock FIFO with a registered storage array and a combinational head.
// A push into a full FIFO is taken when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/psum_collector.sv
// Collects per-lane partial sums into lane FIFOs and emits one packed word
// {kn3,kn2,kn1,kn0} only when every lane has a head available.
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int BIT_WIDTH  = BIT_WIDTH_DEF,
  parameter int NUM_KERNEL = NUM_KERNEL_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int REG_WIDTH  = REG_WIDTH_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [BIT_WIDTH-1:0]            i_psum_kn0,
  input  logic [BIT_WIDTH-1:0]            i_psum_kn1,
  input  logic [BIT_WIDTH-1:0]            i_psum_kn2,
  input  logic [BIT_WIDTH-1:0]            i_psum_kn3,
  input  logic                            i_psum_kn0_val,
  input  logic                            i_psum_kn1_val,
  input  logic                            i_psum_kn2_val,
  input  logic                            i_psum_kn3_val,
  input  logic [REG_WIDTH-1:0]            i_conf_ctrl,
  output logic [BIT_WIDTH*NUM_KERNEL-1:0] o_data,
  output logic                            o_data_val,
  input  logic                            i_data_rdy,
  output logic                            o_overflow,
  output logic [REG_WIDTH-1:0]            o_word_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                            en;
  logic                            clr;
  logic                            unused_ctrl;
  logic [BIT_WIDTH-1:0]            lane_psum [4];
  logic [3:0]                      lane_val;
  logic [NUM_KERNEL-1:0]           wr_req;
  logic [NUM_KERNEL-1:0]           lane_full;
  logic [NUM_KERNEL-1:0]           lane_empty;
  logic [BIT_WIDTH-1:0]            lane_head [NUM_KERNEL];
  logic [CW-1:0]                   lane_count_unused [NUM_KERNEL];
  logic [BIT_WIDTH*NUM_KERNEL-1:0] head_word_p0;
  logic                            pop_p0;
  logic                            drop_p0;

  assign en          = i_conf_ctrl[CTRL_EN];
  assign clr         = i_conf_ctrl[CTRL_CLR];
  assign unused_ctrl = ^i_conf_ctrl[REG_WIDTH-1:2];

  assign lane_psum[0] = i_psum_kn0;
  assign lane_psum[1] = i_psum_kn1;
  assign lane_psum[2] = i_psum_kn2;
  assign lane_psum[3] = i_psum_kn3;
  assign lane_val     = {i_psum_kn3_val, i_psum_kn2_val, i_psum_kn1_val, i_psum_kn0_val};

  // Stage p0: lane FIFOs, all-lanes-present pop decision, head packing
  assign pop_p0  = (&(~lane_empty)) && (!o_data_val || i_data_rdy) && !clr;
  assign drop_p0 = |(wr_req & lane_full & {NUM_KERNEL{~pop_p0}});

  for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_lane
    assign wr_req[k] = lane_val[k] && en && !clr;
    assign head_word_p0[k*BIT_WIDTH +: BIT_WIDTH] = lane_head[k];

    sync_fifo #(
      .WIDTH (BIT_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .push  (wr_req[k]),
      .pop   (pop_p0),
      .din   (lane_psum[k]),
      .dout  (lane_head[k]),
      .full  (lane_full[k]),
      .empty (lane_empty[k]),
      .count (lane_count_unused[k])
    );
  end

  // Stage p1: output register with valid/ready hold
  always_ff @(posedge clk) begin
    if (rst) begin
      o_data     <= '0;
      o_data_val <= 1'b0;
    end else if (clr) begin
      o_data_val <= 1'b0;
    end else if (pop_p0) begin
      o_data     <= head_word_p0;
      o_data_val <= 1'b1;
    end else if (i_data_rdy) begin
      o_data_val <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      o_overflow <= 1'b0;
    end else if (drop_p0) begin
      o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      o_word_cnt <= '0;
    end else if (o_data_val && i_data_rdy) begin
      o_word_cnt <= o_word_cnt + REG_WIDTH'(1);
    end
  end

endmodule
